// File: rtl/retire_trace_checker.sv
// retire_trace_checker: in-order checker for multi-issue retire streams.
// Golden register-write records are pushed into a FIFO. Up to RETIRE_LANES
// retirements per cycle are compared against consecutive FIFO entries.
// The first failure (mismatch, underrun or timeout) is latched, and the
// end-of-benchmark store signals pass.
module retire_trace_checker #(
   parameter int unsigned RETIRE_LANES = 2,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned TIMEOUT      = 1048576,
   parameter logic [31:0] END_ADDR     = 32'h0C
) (
   input  logic                       sys_clk,
   input  logic                       sys_reset_n,
   input  logic                       start,
   input  logic                       gold_valid,
   output logic                       gold_ready,
   input  logic [100:0]               gold_rec,
   input  logic                       trace_done,
   input  logic [RETIRE_LANES-1:0]    rt_valid,
   input  logic [RETIRE_LANES-1:0]    rt_wen,
   input  logic [32*RETIRE_LANES-1:0] rt_pc,
   input  logic [5*RETIRE_LANES-1:0]  rt_waddr,
   input  logic [32*RETIRE_LANES-1:0] rt_wdata,
   input  logic                       mem_wen,
   input  logic [31:0]                mem_addr,
   input  logic [31:0]                mem_wdata,
   output logic [1:0]                 state,
   output logic [1:0]                 fail_code,
   output logic [1:0]                 err_lane,
   output logic [68:0]                err_dut,
   output logic [68:0]                err_gold,
   output logic [31:0]                checked_cnt
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT) + 1;
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PASS = 2'd2, S_FAIL = 2'd3} state_e;
   localparam logic [1:0] FC_NONE = 2'd0, FC_MISMATCH = 2'd1, FC_UNDERRUN = 2'd2, FC_TIMEOUT = 2'd3;

   state_e        state_q, state_d;
   logic [1:0]    code_q, code_d, lane_q, lane_d;
   logic [68:0]   edut_q, edut_d, egold_q, egold_d;
   logic [31:0]   chk_q, chk_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [AW-1:0] head_q;
   logic [CW-1:0] count_q;
   logic [100:0]  mem_q [FIFO_DEPTH];

   // lane evaluation results
   logic [CW-1:0] k;
   logic          lane_fail;
   logic [1:0]    lf_code, lf_lane;
   logic [68:0]   lf_dut, lf_gold, dut_e;
   logic [2:0]    n_ok;
   logic [AW-1:0] ridx;
   logic [100:0]  g;
   logic [32:0]   chk_sum;
   logic          push, pass_cond;

   assign gold_ready = sys_reset_n && (count_q != DEPTH_CNT) && (state_q == S_IDLE || state_q == S_RUN);
   // waddr==0 records complete the handshake but are never stored
   assign push       = gold_valid && gold_ready && (gold_rec[68:64] != 5'd0);
   assign chk_sum    = {1'b0, chk_q} + 33'(n_ok);
   assign pass_cond  = trace_done && (count_q == '0) && mem_wen &&
                       (mem_addr == END_ADDR) && (mem_wdata == '0);

   // Walk lanes in order; the k-th checked lane is compared with head+k.
   always_comb begin
      k = '0; lane_fail = 1'b0; lf_code = FC_NONE; lf_lane = '0;
      lf_dut = '0; lf_gold = '0; n_ok = '0; ridx = '0; g = '0; dut_e = '0;
      for (int i = 0; i < RETIRE_LANES; i++) begin
         dut_e = {rt_pc[32*i +: 32], rt_waddr[5*i +: 5], rt_wdata[32*i +: 32]};
         if (state_q == S_RUN && rt_valid[i] && rt_wen[i] && rt_waddr[5*i +: 5] != 5'd0) begin
            ridx = head_q + k[AW-1:0];
            g    = mem_q[ridx];
            if (!lane_fail) begin
               if (k >= count_q) begin
                  lane_fail = 1'b1; lf_code = FC_UNDERRUN; lf_lane = 2'(i);
                  lf_dut = dut_e; lf_gold = '0;
               end else if (g[100:69] != rt_pc[32*i +: 32] || g[68:64] != rt_waddr[5*i +: 5] ||
                            ((g[63:32] ^ rt_wdata[32*i +: 32]) & g[31:0]) != 32'd0) begin
                  lane_fail = 1'b1; lf_code = FC_MISMATCH; lf_lane = 2'(i);
                  lf_dut = dut_e; lf_gold = g[100:32];
               end else begin
                  n_ok = n_ok + 3'd1;
               end
            end
            k = k + CW'(1);
         end
      end
   end

   // Next-state: FSM, failure capture, checked counter and idle timeout.
   always_comb begin
      state_d = state_q; code_d = code_q; lane_d = lane_q;
      edut_d = edut_q; egold_d = egold_q; chk_d = chk_q; tmo_d = tmo_q;
      case (state_q)
         S_IDLE: if (start) state_d = S_RUN;
         S_RUN: begin
            // OK lanes ahead of a failing lane still count
            chk_d = chk_sum[32] ? 32'hFFFF_FFFF : chk_sum[31:0];
            if (lane_fail) begin
               state_d = S_FAIL; code_d = lf_code; lane_d = lf_lane;
               edut_d = lf_dut; egold_d = lf_gold;
            end else if (k == '0) begin
               if (tmo_q == TMO_LAST) begin
                  state_d = S_FAIL; code_d = FC_TIMEOUT; lane_d = '0;
                  edut_d = '0; egold_d = '0;
               end else begin
                  tmo_d = tmo_q + TW'(1);
                  if (pass_cond) state_d = S_PASS;
               end
            end else begin
               tmo_d = '0;
            end
         end
         default: ;
      endcase
   end

   // Control and result registers with synchronous reset.
   always_ff @(posedge sys_clk) begin
      if (!sys_reset_n) begin
         state_q <= S_IDLE; code_q <= FC_NONE; lane_q <= '0;
         edut_q <= '0; egold_q <= '0; chk_q <= '0; tmo_q <= '0;
         head_q <= '0; count_q <= '0;
      end else begin
         state_q <= state_d; code_q <= code_d; lane_q <= lane_d;
         edut_q <= edut_d; egold_q <= egold_d; chk_q <= chk_d; tmo_q <= tmo_d;
         head_q  <= head_q + AW'(n_ok);
         count_q <= count_q + CW'(push) - CW'(n_ok);
      end
   end

   // FIFO storage; a record written here is first readable next cycle.
   always_ff @(posedge sys_clk) begin
      if (push) mem_q[head_q + count_q[AW-1:0]] <= gold_rec;
   end

   assign state       = state_q;
   assign fail_code   = code_q;
   assign err_lane    = lane_q;
   assign err_dut     = edut_q;
   assign err_gold    = egold_q;
   assign checked_cnt = chk_q;
endmodule

// File: tb/tb_retire_trace_checker.sv
// Scoreboard bench for retire_trace_checker: a queue-based reference model
// predicts the registered outputs of every cycle; a monitor compares them.
module tb_retire_trace_checker;
   localparam int L     = 2;
   localparam int DEPTH = 16;
   localparam int TMO   = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n, start, gold_valid, gold_ready, trace_done, mem_wen;
   logic [100:0]    gold_rec;
   logic [L-1:0]    rt_valid, rt_wen;
   logic [32*L-1:0] rt_pc, rt_wdata;
   logic [5*L-1:0]  rt_waddr;
   logic [31:0]     mem_addr, mem_wdata, checked_cnt;
   logic [1:0]      state, fail_code, err_lane;
   logic [68:0]     err_dut, err_gold;

   retire_trace_checker #(.RETIRE_LANES(L), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO), .END_ADDR(32'h0C)) dut (
      .sys_clk(clk), .sys_reset_n(rst_n), .start(start), .gold_valid(gold_valid),
      .gold_ready(gold_ready), .gold_rec(gold_rec), .trace_done(trace_done),
      .rt_valid(rt_valid), .rt_wen(rt_wen), .rt_pc(rt_pc), .rt_waddr(rt_waddr),
      .rt_wdata(rt_wdata), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .state(state), .fail_code(fail_code), .err_lane(err_lane), .err_dut(err_dut),
      .err_gold(err_gold), .checked_cnt(checked_cnt));

   typedef struct { logic [31:0] pc; logic [4:0] wa; logic [31:0] wd; logic [31:0] mask; } grec_t;
   typedef struct packed {
      logic [1:0] st; logic [1:0] code; logic [1:0] lane;
      logic [68:0] dut; logic [68:0] gold; logic [31:0] cnt; logic rdy;
   } obs_t;

   int    n_tests = 0, n_fail = 0;
   obs_t  exp_q[$];
   grec_t gq[$];    // model FIFO contents
   grec_t pend[$];  // stored records not yet handed to a retire lane

   int          m_state = 0, m_code = 0, m_lane = 0, m_idle = 0;
   logic [68:0] m_dut = '0, m_gold = '0;
   longint      m_cnt = 0;
   bit          m_stored;

   // Reference model: one clock edge worth of behaviour from the driven inputs.
   task automatic model_step();
      grec_t r;
      bit rdy, failed;
      int k, ok, nxt;
      logic [68:0] d;
      obs_t e;
      m_stored = 0;
      if (!rst_n) begin
         m_state = 0; m_code = 0; m_lane = 0; m_dut = '0; m_gold = '0;
         m_cnt = 0; m_idle = 0; gq.delete();
      end else begin
         rdy = (gq.size() < DEPTH) && (m_state <= 1);
         nxt = m_state;
         if (m_state == 0 && start) nxt = 1;
         else if (m_state == 1) begin
            k = 0; ok = 0; failed = 0;
            for (int i = 0; i < L; i++) begin
               if (rt_valid[i] && rt_wen[i] && rt_waddr[5*i +: 5] != 5'd0) begin
                  d = {rt_pc[32*i +: 32], rt_waddr[5*i +: 5], rt_wdata[32*i +: 32]};
                  if (!failed) begin
                     if (k >= gq.size()) begin
                        failed = 1; m_code = 2; m_lane = i; m_dut = d; m_gold = '0;
                     end else begin
                        r = gq[k];
                        if (r.pc == rt_pc[32*i +: 32] && r.wa == rt_waddr[5*i +: 5] &&
                            (rt_wdata[32*i +: 32] & r.mask) == (r.wd & r.mask)) ok++;
                        else begin
                           failed = 1; m_code = 1; m_lane = i; m_dut = d; m_gold = {r.pc, r.wa, r.wd};
                        end
                     end
                  end
                  k++;
               end
            end
            for (int j = 0; j < ok; j++) gq.delete(0);
            m_cnt = m_cnt + ok;
            if (m_cnt > 64'hFFFF_FFFF) m_cnt = 64'hFFFF_FFFF;
            m_idle = (k == 0) ? m_idle + 1 : 0;
            if (failed) nxt = 3;
            else if (m_idle == TMO) begin
               nxt = 3; m_code = 3; m_lane = 0; m_dut = '0; m_gold = '0;
            end else if (k == 0 && trace_done && gq.size() == 0 && mem_wen &&
                         mem_addr == 32'h0C && mem_wdata == 32'd0) nxt = 2;
         end
         if (gold_valid && rdy && gold_rec[68:64] != 5'd0) begin
            r.pc = gold_rec[100:69]; r.wa = gold_rec[68:64]; r.wd = gold_rec[63:32]; r.mask = gold_rec[31:0];
            gq.push_back(r); m_stored = 1;
         end
         m_state = nxt;
      end
      e.st = 2'(m_state); e.code = 2'(m_code); e.lane = 2'(m_lane);
      e.dut = m_dut; e.gold = m_gold; e.cnt = m_cnt[31:0];
      e.rdy = rst_n && (gq.size() < DEPTH) && (m_state <= 1);
      exp_q.push_back(e);
   endtask

   // Monitor: every clock edge the DUT presents new registered outputs.
   always @(posedge clk) begin : mon
      obs_t e, a;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {state, fail_code, err_lane, err_dut, err_gold, checked_cnt, gold_ready};
         n_tests++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL outputs t=%0t: got st=%0d code=%0d lane=%0d cnt=%0d rdy=%0b dut=%h gold=%h | want st=%0d code=%0d lane=%0d cnt=%0d rdy=%0b dut=%h gold=%h",
                     $time, a.st, a.code, a.lane, a.cnt, a.rdy, a.dut, a.gold,
                     e.st, e.code, e.lane, e.cnt, e.rdy, e.dut, e.gold);
         end
      end
   end

   task automatic chk(input string name, input logic [68:0] act, input logic [68:0] want);
      n_tests++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
      end
   endtask

   task automatic cyc();
      grec_t r;
      model_step();
      if (m_stored) begin
         r.pc = gold_rec[100:69]; r.wa = gold_rec[68:64]; r.wd = gold_rec[63:32]; r.mask = gold_rec[31:0];
         pend.push_back(r);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clr_in();
      start = 0; gold_valid = 0; gold_rec = '0; trace_done = 0;
      rt_valid = '0; rt_wen = '0; rt_pc = '0; rt_waddr = '0; rt_wdata = '0;
      mem_wen = 0; mem_addr = '0; mem_wdata = '0;
   endtask

   task automatic lane(input int i, input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] wd);
      rt_valid[i] = 1'b1; rt_wen[i] = 1'b1;
      rt_pc[32*i +: 32] = pc; rt_waddr[5*i +: 5] = wa; rt_wdata[32*i +: 32] = wd;
   endtask

   task automatic push_rec(input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] mask);
      gold_valid = 1'b1; gold_rec = {pc, wa, wd, mask};
   endtask

   task automatic do_reset();
      clr_in(); rst_n = 0; cyc(); rst_n = 1;
   endtask

   task automatic end_store();
      trace_done = 1; mem_wen = 1; mem_addr = 32'h0C; mem_wdata = 32'd0;
   endtask

   initial begin : wdog
      #500000;
      $display("FAIL watchdog: run did not reach its summary");
      $fatal(1);
   end

   initial begin : stim
      grec_t r;
      logic [31:0] pcc, wd, mk;
      logic [4:0]  wa;
      int sel;

      // reset state
      clr_in(); rst_n = 0; cyc(); cyc();
      chk("reset_state", 69'(state), 69'(0));
      chk("reset_code", 69'(fail_code), 69'(0));
      chk("reset_cnt", 69'(checked_cnt), 69'(0));
      chk("reset_err", err_dut | err_gold, 69'(0));
      rst_n = 1; cyc();
      chk("idle_ready", 69'(gold_ready), 69'(1));

      // two lanes, two cycles, four preloaded records
      for (int i = 0; i < 4; i++) begin
         clr_in(); push_rec(32'(4*i), 5'(i+1), 32'h100 + 32'(i), 32'hFFFF_FFFF); cyc();
      end
      clr_in(); start = 1; cyc();
      chk("start_run", 69'(state), 69'(1));
      clr_in(); lane(0, 32'h0, 5'd1, 32'h100); lane(1, 32'h4, 5'd2, 32'h101); cyc();
      clr_in(); lane(0, 32'h8, 5'd3, 32'h102); lane(1, 32'hC, 5'd4, 32'h103); cyc();
      chk("t1_cnt", 69'(checked_cnt), 69'(4));
      chk("t1_state", 69'(state), 69'(1));

      // masked data compare passes
      clr_in(); push_rec(32'h10, 5'd5, 32'h1234_5678, 32'hFFFF_FFFF); cyc();
      clr_in(); push_rec(32'h14, 5'd6, 32'hBEEF_0000, 32'h0000_FFFF); cyc();
      clr_in(); lane(0, 32'h10, 5'd5, 32'h1234_5678); lane(1, 32'h14, 5'd6, 32'hDEAD_0000); cyc();
      chk("mask_cnt", 69'(checked_cnt), 69'(6));
      chk("mask_state", 69'(state), 69'(1));

      // waddr==0 lane ignored, lane1 takes the head
      clr_in(); push_rec(32'h18, 5'd7, 32'h7, 32'hFFFF_FFFF); cyc();
      clr_in(); lane(0, 32'h99, 5'd0, 32'h55); lane(1, 32'h18, 5'd7, 32'h7); cyc();
      chk("skip_cnt", 69'(checked_cnt), 69'(7));
      chk("skip_state", 69'(state), 69'(1));

      // full mask: lane1 mismatch, lane0 still counted
      clr_in(); push_rec(32'h1C, 5'd8, 32'h88, 32'hFFFF_FFFF); cyc();
      clr_in(); push_rec(32'h20, 5'd9, 32'hBEEF_0000, 32'hFFFF_FFFF); cyc();
      clr_in(); lane(0, 32'h1C, 5'd8, 32'h88); lane(1, 32'h20, 5'd9, 32'hDEAD_0000); cyc();
      chk("mm_state", 69'(state), 69'(3));
      chk("mm_code", 69'(fail_code), 69'(1));
      chk("mm_lane", 69'(err_lane), 69'(1));
      chk("mm_dut", err_dut, {32'h20, 5'd9, 32'hDEAD_0000});
      chk("mm_gold", err_gold, {32'h20, 5'd9, 32'hBEEF_0000});
      chk("mm_cnt", 69'(checked_cnt), 69'(8));
      chk("mm_ready", 69'(gold_ready), 69'(0));

      // underrun on empty FIFO
      do_reset(); start = 1; cyc();
      clr_in(); lane(0, 32'h40, 5'd3, 32'h5); cyc();
      chk("ur_state", 69'(state), 69'(3));
      chk("ur_code", 69'(fail_code), 69'(2));
      chk("ur_lane", 69'(err_lane), 69'(0));
      chk("ur_dut", err_dut, {32'h40, 5'd3, 32'h5});
      chk("ur_gold", err_gold, 69'(0));
      clr_in(); push_rec(32'h44, 5'd2, 32'h1, 32'hFFFF_FFFF); cyc();
      chk("ur_ready", 69'(gold_ready), 69'(0));
      chk("ur_sticky", 69'(state), 69'(3));

      // timeout after 16 idle RUN cycles
      do_reset(); start = 1; cyc();
      for (int i = 0; i < 15; i++) begin clr_in(); cyc(); end
      chk("tmo_15", 69'(state), 69'(1));
      clr_in(); cyc();
      chk("tmo_state", 69'(state), 69'(3));
      chk("tmo_code", 69'(fail_code), 69'(3));
      chk("tmo_err", err_dut | err_gold, 69'(0));

      // pass on end store; wrong data or leftover record stays RUN
      do_reset(); start = 1; cyc();
      clr_in(); end_store(); mem_wdata = 32'd1; cyc();
      chk("pass_wdata1", 69'(state), 69'(1));
      clr_in(); end_store(); cyc();
      chk("pass_state", 69'(state), 69'(2));
      clr_in(); cyc();
      chk("pass_sticky", 69'(state), 69'(2));
      do_reset(); push_rec(32'h50, 5'd1, 32'h1, 32'hFFFF_FFFF); cyc();
      clr_in(); start = 1; cyc();
      clr_in(); end_store(); cyc();
      chk("pass_left1", 69'(state), 69'(1));

      // randomized episodes
      for (int ep = 0; ep < 30; ep++) begin
         do_reset(); pend.delete(); pcc = 32'h1000;
         for (int p = 0; p < int'($urandom_range(0, 3)); p++) begin
            clr_in(); push_rec(pcc, 5'($urandom_range(1, 31)), $urandom, 32'hFFFF_FFFF);
            pcc += 4; cyc();
         end
         clr_in(); start = 1; cyc();
         for (int c = 0; c < 50; c++) begin
            clr_in();
            if (c < 35 && $urandom_range(0, 9) < 7) begin
               wa = 5'($urandom_range(0, 31));
               sel = int'($urandom_range(0, 2));
               mk = (sel == 0) ? 32'hFFFF_FFFF : (sel == 1) ? 32'h0000_FFFF : $urandom;
               push_rec(pcc, wa, $urandom, mk); pcc += 4;
            end
            for (int i = 0; i < L; i++) begin
               sel = int'($urandom_range(0, 99));
               if (sel < 45 && pend.size() > 0) begin
                  r = pend[0]; pend.delete(0);
                  wd = r.wd ^ ($urandom & ~r.mask);
                  if ($urandom_range(0, 59) == 0) r.pc = r.pc ^ 32'h4;
                  lane(i, r.pc, r.wa, wd);
               end else if (sel < 55) begin
                  lane(i, $urandom, 5'($urandom_range(0, 31)), $urandom);
                  if (sel < 50) rt_wen[i] = 1'b0; else rt_waddr[5*i +: 5] = 5'd0;
               end else if (sel < 57) begin
                  lane(i, $urandom, 5'($urandom_range(1, 31)), $urandom);
               end
            end
            trace_done = (c >= 35);
            if ($urandom_range(0, 9) < 2) begin
               mem_wen   = 1'b1;
               mem_addr  = ($urandom_range(0, 3) == 0) ? 32'h10 : 32'h0C;
               mem_wdata = ($urandom_range(0, 3) == 0) ? 32'h1 : 32'h0;
            end
            cyc();
         end
      end

      clr_in(); cyc();
      chk("scoreboard_drained", 69'(exp_q.size()), 69'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
